// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: walks all input vectors onto a gate under test, checks each output against TRUTH, reports verdict/errors/first failure
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a run (accepted in IDLE or DONE only)
//   dut_out         : gate-under-test output
//   dut_in          : registered vector driven to the gate inputs
//   busy, done      : run in progress / run finished (held until next start or rst)
//   pass            : valid with done, 1 iff no mismatches
//   err_count       : mismatching vectors in the current/last run
//   first_fail      : lowest failing vector, valid when fail_seen
//   fail_seen       : at least one mismatch in the current/last run
module gate_tt_sequencer #(
  parameter int N_IN = 2,
  parameter int SETTLE = 3,
  parameter logic [2**N_IN-1:0] TRUTH = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_seen
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST = '1;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t          r_state, w_state;
  logic [N_IN-1:0] r_in, w_in, r_first, w_first;
  logic [N_IN:0]   r_err, w_err;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_busy, w_busy, r_done, w_done, r_pass, w_pass, r_fs, w_fs;
  logic            r_dout, w_mis;
  // Case inequality: an X/Z output is a mismatch in simulation; synthesis compares the resolved value.
  assign w_mis = r_dout !== TRUTH[r_in];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_in    <= '0;
      r_first <= '0;
      r_err   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fs    <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_in    <= w_in;
      r_first <= w_first;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_fs    <= w_fs;
      r_dout  <= dut_out;
    end
  end
  always_comb begin
    w_state = r_state;
    w_in    = r_in;
    w_first = r_first;
    w_err   = r_err;
    w_cnt   = r_cnt;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;
    w_fs    = r_fs;
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        w_state = S_APPLY;
        w_in    = '0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_pass  = 1'b0;
        w_err   = '0;
        w_fs    = 1'b0;
        w_first = '0;
      end
      S_APPLY: begin
        w_cnt   = '0;
        w_state = S_SETTLE;
      end
      S_SETTLE: if (r_cnt == CW'(SETTLE - 1)) w_state = S_SAMPLE;
        else w_cnt = r_cnt + 1'b1;
      S_SAMPLE: begin
        if (w_mis) begin
          w_err = r_err + 1'b1;
          if (!r_fs) begin
            w_first = r_in;
            w_fs    = 1'b1;
          end
        end
        if (r_in == LAST) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = w_err == '0;
        end else begin
          w_in    = r_in + 1'b1;
          w_state = S_APPLY;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  assign dut_in     = r_in;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;
  assign fail_seen  = r_fs;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: directed checks of gate_tt_sequencer against NOR2, stuck-at-0, OR2 and AND2 gate models
module tb_gate_tt_sequencer;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic       dut_out;
  logic [1:0] dut_in, first_fail;
  logic [2:0] err_count;
  logic       busy, done, pass, fail_seen;
  int         mode = 0;
  int         vectors = 0, miscompares = 0;

  gate_tt_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out), .dut_in(dut_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_seen(fail_seen)
  );

  always #5 clk = ~clk;

  assign dut_out = mode == 0 ? ~(dut_in[0] | dut_in[1]) : mode == 1 ? 1'b0 :
                   mode == 2 ? (dut_in[0] | dut_in[1]) : (dut_in[0] & dut_in[1]);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input int poke, input int rst_at,
                     input int exp_err, input logic [1:0] exp_first, input logic exp_fs);
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (dut_in !== 2'd0 || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 3'd0 || fail_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept: dut_in=%0d busy=%b done=%b pass=%b err=%0d fs=%b, need 0 1 0 0 0 0",
               name, dut_in, busy, done, pass, err_count, fail_seen);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k == poke) start = 1'b1;
      if (k == rst_at) rst = 1'b1;
      tick();
      start = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        vectors++;
        if (dut_in !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || err_count !== 3'd0 || fail_seen !== 1'b0) begin
          miscompares++;
          $display("FAIL %s reset: dut_in=%0d busy=%b done=%b err=%0d fs=%b, need all 0",
                   name, dut_in, busy, done, err_count, fail_seen);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || dut_in !== 2'd0) begin
          miscompares++;
          $display("FAIL %s idle_after_rst: busy=%b dut_in=%0d, need 0 0", name, busy, dut_in);
        end
        return;
      end
      vectors++;
      if (dut_in !== 2'((k < 20) ? k / 5 : 3) || busy !== (k < 20) || done !== (k == 20)) begin
        miscompares++;
        $display("FAIL %s edge%0d: dut_in=%0d busy=%b done=%b, need %0d %b %b",
                 name, k, dut_in, busy, done, (k < 20) ? k / 5 : 3, k < 20, k == 20);
      end
    end
    vectors++;
    if (err_count !== 3'(exp_err) || fail_seen !== exp_fs || pass !== (exp_err == 0) ||
        (exp_fs && first_fail !== exp_first)) begin
      miscompares++;
      $display("FAIL %s verdict: err=%0d fs=%b pass=%b first=%0d, need %0d %b %b %0d",
               name, err_count, fail_seen, pass, first_fail, exp_err, exp_fs, exp_err == 0, exp_first);
    end
    repeat (3) tick();
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || err_count !== 3'(exp_err) || pass !== (exp_err == 0) || dut_in !== 2'd3) begin
      miscompares++;
      $display("FAIL %s hold: done=%b busy=%b err=%0d pass=%b dut_in=%0d, need 1 0 %0d %b 3",
               name, done, busy, err_count, pass, dut_in, exp_err, exp_err == 0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) tick();
    vectors++;
    if (dut_in !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 3'd0 || fail_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: dut_in=%0d busy=%b done=%b pass=%b err=%0d fs=%b, need all 0",
               dut_in, busy, done, pass, err_count, fail_seen);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_nor_pass;
    mode = 0;
    run("nor2", 0, 0, 0, 2'd0, 1'b0);
  endtask

  task automatic test_stuck0;
    mode = 1;
    run("stuck0", 0, 0, 1, 2'd0, 1'b1);
  endtask

  task automatic test_or_and;
    mode = 2;
    run("or2", 0, 0, 4, 2'd0, 1'b1);
    mode = 3;
    run("and2", 0, 0, 2, 2'd0, 1'b1);
  endtask

  task automatic test_start_ignored;
    mode = 0;
    run("start_in_settle", 7, 0, 0, 2'd0, 1'b0);
  endtask

  task automatic test_restart_after_fail;
    mode = 1;
    run("fail_before_restart", 0, 0, 1, 2'd0, 1'b1);
    mode = 0;
    run("restart_pass", 0, 0, 0, 2'd0, 1'b0);
  endtask

  task automatic test_rst_midrun;
    mode = 2;
    run("rst_in_settle", 0, 12, 0, 2'd0, 1'b0);
    mode = 0;
    run("run_after_rst", 0, 0, 0, 2'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_stuck0();
    test_or_and();
    test_start_ignored();
    test_restart_after_fail();
    test_rst_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
Exhaustive truth-table sequencer for a small combinational standard-cell gate under test, for example the 2-input CMOS NOR cell.
- Walks every input vector onto the gate inputs in ascending binary order.
- Holds each vector for a programmable settle window, then samples the gate output and compares it with the expected truth table.
- Reports a pass/fail verdict, the error count and the first failing vector.
- Sits between the cell-characterisation bench/top and the switch-level gate instance, replacing free-running per-input clock stimuli.

Parameters:
N_IN, 2, number of gate inputs; legal range 1..4.
SETTLE, 3, cycles the vector is held before sampling; must be >= 1.
TRUTH, 4'b0001, expected output per vector, 2**N_IN bits; bit v is the expected dut_out for dut_in==v. The default is NOR2.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a run; sampled only in IDLE or DONE
dut_out  input  1  gate-under-test output
dut_in  output  N_IN  registered vector driven to the gate inputs
busy  output  1  high from APPLY through the last SAMPLE
done  output  1  high in DONE; held until the next accepted start or rst
pass  output  1  valid while done; 1 iff err_count==0
err_count  output  N_IN+1  number of mismatching vectors in the current/last run
first_fail  output  N_IN  lowest failing vector; valid when fail_seen
fail_seen  output  1  at least one mismatch in the current/last run

Behaviour:
- Reset: on rst=1 at a clk edge, all outputs go to 0 and the state goes to IDLE; a vector counter and a settle counter are cleared.
  - rst has priority over every other event, including mid-run.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: with start=1, go to APPLY. On the same edge: dut_in<=0, busy<=1, err_count<=0, fail_seen<=0, first_fail<=0.
- DONE: with start=1, same action as IDLE (restart). With start=0, hold state and all outputs.
- APPLY: one cycle; dut_in is already stable. Clear the settle counter and go to SETTLE.
- SETTLE: stay exactly SETTLE cycles, counting each edge; leave to SAMPLE on the edge where the count reaches SETTLE-1.
- SAMPLE: one cycle; compare the registered dut_out with TRUTH[dut_in].
  - Mismatch: err_count++. If fail_seen==0, then first_fail<=dut_in and fail_seen<=1.
  - If dut_in == 2**N_IN-1: go to DONE, busy<=0, done<=1, pass<=(next err_count==0).
  - Else: dut_in<=dut_in+1 and go to APPLY.
- dut_in changes only on the IDLE/DONE->APPLY edge and on the SAMPLE->APPLY edge. It never changes during SETTLE or SAMPLE.
- Cost per vector: SETTLE+2 edges. The last SAMPLE edge occurs 2**N_IN*(SETTLE+2) edges after the start-accept edge, and done is high after it.
  - Defaults: 20 edges.
- start while busy=1 is ignored with no effect.
- done and pass drop on the start-accept edge.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- Mismatch rule for an X or Z dut_out:
  - Simulation: counts as a mismatch (case inequality).
  - Synthesis: compares the resolved value.
- pass, err_count, first_fail and fail_seen are stable throughout DONE.

Test Plan:
- Reset: hold rst for 3 cycles -> dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0. A start pulse asserted together with rst is ignored.
- Ideal NOR2 model on dut_out, start pulse -> dut_in steps 0,1,2,3, each held 5 cycles. done=1 exactly 20 edges after accept; pass=1, err_count=0, fail_seen=0.
- dut_out stuck-at-0 -> only vector 0 mismatches: err_count=1, first_fail=0, fail_seen=1, pass=0. done timing is the same 20 edges.
- OR2 model (inverted NOR) -> err_count=4, first_fail=0, pass=0. Repeat with an AND2 model -> err_count=2 (vectors 0 and 3), first_fail=0.
- start pulsed during SETTLE of vector 1 -> ignored, sequence unchanged. start in DONE with the ideal model after a failed run -> counters clear, rerun gives pass=1.
- rst asserted during SETTLE of vector 2 -> next cycle IDLE, dut_in=0, busy=0, err_count=0. A subsequent start gives a full 20-edge run from vector 0.
